// File: rtl/pcm_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pcm_arb_pkg
// Description : Shared state encodings, parameter defaults and helpers for the
//               PCM memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package pcm_arb_pkg;

  // Parameter defaults shared by the arbiter and its users
  localparam int N_CPU_DEF      = 4;
  localparam int CPU_ADDR_W_DEF = 20;
  localparam int ADDR_W_DEF     = 11;
  localparam int DATA_W_DEF     = 16;
  localparam int RD_LAT_DEF     = 1;
  localparam int ARB_MODE_DEF   = 0;

  // Transaction state machine encoding
  typedef logic [2:0] state_t;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERR   = 3'd4;

  // Byte-enable width for a given data width
  function automatic int be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pcm_mem_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational N-way arbiter. Round-robin search upward from a
//               pointer (mode_i=0) or fixed lowest-index priority (mode_i=1).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic             mode_i,
  output logic [N-1:0]     gnt_o,
  output logic             valid_o
);

  // Scan candidates in priority order; the first active one wins
  always_comb begin
    int  idx;
    logic found;
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      if (mode_i) begin
        idx = k;
      end else begin
        idx = int'(ptr_i) + k;
        if (idx >= N) idx = idx - N;
      end
      if (req_i[idx] && !found) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule
`default_nettype wire

// File: rtl/pcm_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pcm_mem_arbiter
// Description : Shares the single PCM on-chip memory port among N_CPU masters
//               with round-robin or fixed-priority arbitration, registered
//               per-CPU read data, one-cycle ready pulses and address trapping.
// Revision    : 1.0 - initial release
// ============================================================================
module pcm_mem_arbiter
  import pcm_arb_pkg::*;
#(
  parameter int N_CPU      = N_CPU_DEF,
  parameter int CPU_ADDR_W = CPU_ADDR_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int RD_LAT     = RD_LAT_DEF,
  parameter int ARB_MODE   = ARB_MODE_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CPU-1:0]            cpu_ce_n,
  input  logic [N_CPU-1:0]            cpu_we_n,
  input  logic [N_CPU*CPU_ADDR_W-1:0] cpu_addr,
  input  logic [N_CPU*DATA_W-1:0]     cpu_wdata,
  output logic [N_CPU-1:0]            cpu_ready,
  output logic [N_CPU*DATA_W-1:0]     cpu_rdata,
  output logic [N_CPU-1:0]            cpu_err,
  input  logic                        err_clr,
  output logic [ADDR_W-1:0]           mem_address,
  output logic                        mem_chipselect,
  output logic                        mem_clken,
  output logic                        mem_write,
  output logic [DATA_W-1:0]           mem_writedata,
  output logic [DATA_W/8-1:0]         mem_byteenable,
  input  logic [DATA_W-1:0]           mem_readdata
);

  localparam int PTR_W = (N_CPU > 1) ? $clog2(N_CPU) : 1;
  localparam int BE_W  = be_width(DATA_W);

  state_t                    state_q, state_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic [PTR_W-1:0]          win_q, win_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [DATA_W-1:0]         wdata_q, wdata_d;
  logic                      we_q, we_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [N_CPU*DATA_W-1:0]   rdata_q, rdata_d;
  logic [N_CPU-1:0]          err_q, err_d;

  logic [N_CPU-1:0]          arb_gnt;
  logic                      arb_valid;
  logic [PTR_W-1:0]          gnt_idx;
  logic [CPU_ADDR_W-1:0]     sel_addr;
  logic [DATA_W-1:0]         sel_wdata;
  logic                      sel_we_n;
  logic                      issue;

  rr_arbiter #(
    .N     (N_CPU),
    .PTR_W (PTR_W)
  ) u_arb (
    .req_i   (~cpu_ce_n),
    .ptr_i   (ptr_q),
    .mode_i  (ARB_MODE != 0),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  // Encode the one-hot grant into a CPU index
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < N_CPU; i++) begin
      if (arb_gnt[i]) gnt_idx = PTR_W'(i);
    end
  end

  assign sel_addr  = cpu_addr[int'(gnt_idx)*CPU_ADDR_W +: CPU_ADDR_W];
  assign sel_wdata = cpu_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
  assign sel_we_n  = cpu_we_n[gnt_idx];

  // Next-state logic for the transaction FSM and its datapath registers
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    // A new error set below overrides a coincident clear for that bit
    err_d   = err_clr ? '0 : err_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          win_d   = gnt_idx;
          addr_d  = sel_addr[ADDR_W-1:0];
          wdata_d = sel_wdata;
          we_d    = ~sel_we_n;
          ptr_d   = (gnt_idx == PTR_W'(N_CPU - 1)) ? '0 : gnt_idx + 1'b1;
          if (sel_addr[CPU_ADDR_W-1:ADDR_W] != '0) begin
            // Trap now so rdata/err are already visible with the ready pulse
            err_d[gnt_idx]                          = 1'b1;
            rdata_d[int'(gnt_idx)*DATA_W +: DATA_W] = '0;
            state_d                                 = ST_ERR;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_DONE;
        end else begin
          cnt_d   = 2'(RD_LAT - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          rdata_d[int'(win_q)*DATA_W +: DATA_W] = mem_readdata;
          state_d                               = ST_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight transaction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Ready pulse to the current winner on completion or trap
  always_comb begin
    cpu_ready = '0;
    if (state_q == ST_DONE || state_q == ST_ERR) cpu_ready[win_q] = 1'b1;
  end

  // Memory strobes and buses are only active in the issue cycle
  assign issue          = (state_q == ST_ISSUE);
  assign mem_chipselect = issue;
  assign mem_write      = issue & we_q;
  assign mem_address    = issue ? addr_q : '0;
  assign mem_writedata  = issue ? wdata_q : '0;
  assign mem_byteenable = issue ? {BE_W{1'b1}} : '0;
  assign mem_clken      = 1'b1;

  assign cpu_rdata = rdata_q;
  assign cpu_err   = err_q;

endmodule
`default_nettype wire
